// File: rtl/reg_file_pkg.sv
// Shared constants and clear-sequencer state type for the multi-read-port register file.
// Optional build macro: REG_FILE_MP_ZERO_REG_EN (entry 0 hard-wired to zero).
package reg_file_pkg;

  localparam int RF_DATA_W = 24;
  localparam int RF_ADDR_W = 5;
  localparam int RF_NUM_RD = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } clr_state_e;

endpackage

// File: rtl/reg_file_clear_seq.sv
// Post-reset clear sequencer: sweeps every entry to zero, then parks in RUN.
// Timing is identical with or without REG_FILE_MP_ZERO_REG_EN.
module reg_file_clear_seq
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              init_busy
);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign clr_addr  = clr_cnt_q;
  assign init_busy = (state_q == CLEAR);

endmodule

// File: rtl/reg_file_mp.sv
// Register file with one write port and NUM_RD registered read ports, write-first bypass.
// Define REG_FILE_MP_ZERO_REG_EN to make entry 0 read as zero and discard its writes.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = RF_NUM_RD
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic                     init_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              ext_we;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  reg_file_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .init_busy (init_busy)
  );

  // The sweep owns the write port until it finishes; external writes are dropped meanwhile.
  always_comb begin
`ifdef REG_FILE_MP_ZERO_REG_EN
    ext_we    = wr_en && !init_busy && (wr_addr != '0);
`else
    ext_we    = wr_en && !init_busy;
`endif
    mem_we    = clr_we || ext_we;
    mem_waddr = clr_we ? clr_addr : wr_addr;
    mem_wdata = clr_we ? '0 : wr_data;
  end

  // NOTE: the array has no reset; the clear sequencer zeroes it, keeping it mappable to RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              hit;
    logic [DATA_W-1:0] rd_data_d, rd_data_q;

    assign addr = rd_addr[i*ADDR_W +: ADDR_W];

    always_comb begin
      rd_data_d = rd_data_q;
      hit       = wr_en && (wr_addr == addr);
      if (init_busy) begin
        rd_data_d = '0;
      end else if (rd_en[i]) begin
        rd_data_d = hit ? wr_data : mem_q[addr];
`ifdef REG_FILE_MP_ZERO_REG_EN
        if (addr == '0) rd_data_d = '0;
`endif
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_data_q <= '0;
      else        rd_data_q <= rd_data_d;
    end

    assign rd_data[i*DATA_W +: DATA_W] = rd_data_q;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp (default parameters, two read ports).
// Expectations follow REG_FILE_MP_ZERO_REG_EN when it is defined for the build.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [23:0] wr_data;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [47:0] rd_data;
  logic        init_busy;

  int n_checks = 0;
  int n_fail   = 0;

  reg_file_mp dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] fill_val(input int a);
`ifdef REG_FILE_MP_ZERO_REG_EN
    if (a == 0) return 24'h0;
`endif
    return 24'(a * 3);
  endfunction

  function automatic logic [23:0] zero_wr_val();
`ifdef REG_FILE_MP_ZERO_REG_EN
    return 24'h000000;
`else
    return 24'h123456;
`endif
  endfunction

  task automatic read2(input int a0, input int a1);
    rd_en   = 2'b11;
    rd_addr = {5'(a1), 5'(a0)};
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_en   = '0;
    rd_addr = '0;

    repeat (3) tick();
    check("rst_busy", {23'b0, init_busy}, 24'd1);
    check("rst_p0", rd_data[23:0], 24'h0);
    check("rst_p1", rd_data[47:24], 24'h0);

    // Release reset; writes and reads are attempted throughout the sweep.
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      wr_en   = 1'b1;
      wr_addr = 5'(k - 1);
      wr_data = 24'h5A5A5A;
      read2(k - 1, 32 - k);
      tick();
      check($sformatf("sweep_busy_%0d", k), {23'b0, init_busy}, (k < 32) ? 24'd1 : 24'd0);
      check($sformatf("sweep_p0_%0d", k), rd_data[23:0], 24'h0);
    end
    wr_en = 1'b0;

    for (int a = 0; a < 32; a++) begin
      read2(a, 31 - a);
      tick();
      check($sformatf("clr_p0_%0d", a), rd_data[23:0], 24'h0);
      check($sformatf("clr_p1_%0d", a), rd_data[47:24], 24'h0);
    end

    // Fill with addr*3, then read back in opposite orders on the two ports.
    rd_en = 2'b00;
    for (int a = 0; a < 32; a++) begin
      wr_en   = 1'b1;
      wr_addr = 5'(a);
      wr_data = 24'(a * 3);
      tick();
    end
    wr_en = 1'b0;
    for (int a = 0; a < 32; a++) begin
      read2(a, 31 - a);
      tick();
      check($sformatf("fill_p0_%0d", a), rd_data[23:0], fill_val(a));
      check($sformatf("fill_p1_%0d", a), rd_data[47:24], fill_val(31 - a));
    end

    // Write-first bypass on both ports reading the written address.
    wr_en   = 1'b1;
    wr_addr = 5'd7;
    wr_data = 24'hABCDEF;
    read2(7, 7);
    tick();
    check("byp_p0", rd_data[23:0], 24'hABCDEF);
    check("byp_p1", rd_data[47:24], 24'hABCDEF);
    wr_addr = 5'd7;
    wr_data = 24'h777777;
    read2(8, 8);
    tick();
    check("nobyp_p0", rd_data[23:0], 24'd24);
    wr_en = 1'b0;
    read2(8, 7);
    tick();
    check("byp_after_p1", rd_data[47:24], 24'h777777);
    read2(7, 9);
    tick();
    check("byp_after_p0", rd_data[23:0], 24'h777777);
    check("byp_after_p1b", rd_data[47:24], 24'd27);

    // Hold: ports disabled while their addresses are overwritten.
    read2(3, 4);
    tick();
    check("hold_pre_p0", rd_data[23:0], 24'd9);
    check("hold_pre_p1", rd_data[47:24], 24'd12);
    rd_en = 2'b00;
    for (int k = 0; k < 5; k++) begin
      wr_en   = 1'b1;
      wr_addr = (k % 2 == 0) ? 5'd3 : 5'd4;
      wr_data = 24'h111111 + 24'(k);
      tick();
      check($sformatf("hold_p0_%0d", k), rd_data[23:0], 24'd9);
      check($sformatf("hold_p1_%0d", k), rd_data[47:24], 24'd12);
    end
    wr_en = 1'b0;
    read2(3, 4);
    tick();
    check("hold_post_p0", rd_data[23:0], 24'h111115);
    check("hold_post_p1", rd_data[47:24], 24'h111114);

    // Entry 0 write with a simultaneous read of address 0.
    wr_en   = 1'b1;
    wr_addr = 5'd0;
    wr_data = 24'h123456;
    read2(0, 0);
    tick();
    check("zero_byp_p0", rd_data[23:0], zero_wr_val());
    wr_en = 1'b0;
    read2(0, 1);
    tick();
    check("zero_rd_p0", rd_data[23:0], zero_wr_val());
    check("zero_rd_p1", rd_data[47:24], 24'd3);

    // Mid-sweep reset: abort after 10 sweep cycles, expect a full restart.
    wr_en   = 1'b1;
    wr_addr = 5'd20;
    wr_data = 24'hC0FFEE;
    rd_en   = 2'b00;
    tick();
    wr_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {23'b0, init_busy}, 24'd1);
    check("mid_rst_p0", rd_data[23:0], 24'h0);
    check("mid_rst_p1", rd_data[47:24], 24'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("part_busy_%0d", k), {23'b0, init_busy}, 24'd1);
    end
    rst_n = 1'b0;
    #1;
    check("abort_busy", {23'b0, init_busy}, 24'd1);
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      check($sformatf("resweep_busy_%0d", k), {23'b0, init_busy}, (k < 32) ? 24'd1 : 24'd0);
    end
    read2(31, 5);
    tick();
    check("resweep_p0_31", rd_data[23:0], 24'h0);
    check("resweep_p1_5", rd_data[47:24], 24'h0);
    read2(20, 7);
    tick();
    check("resweep_p0_20", rd_data[23:0], 24'h0);
    check("resweep_p1_7", rd_data[47:24], 24'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-read-port register file; next generation of the processor's 32x24 dual-port reg_file.
- One write port and NUM_RD independent synchronous read ports, all on one clock.
- Write-first bypass: a read of the address being written returns the new data.
- Hardware clear sequencer zeroes every entry after reset. The core does not issue reads or writes until init_busy falls.

Parameters:
- DATA_W, 24, width of each register entry.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries (32 by default).
- NUM_RD, 2, number of read ports (1..4).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  write enable.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  write data.
- rd_en  input  NUM_RD  per-port read enable.
- rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port i at [i*ADDR_W +: ADDR_W].
- rd_data  output  NUM_RD*DATA_W  packed registered read data; port i at [i*DATA_W +: DATA_W].
- init_busy  output  1  high while reset is asserted and during the clear sweep.

Behaviour:
- Reset (rst_n low, async):
  - rd_data = 0, init_busy = 1.
  - Clear FSM forced to CLEAR with clr_cnt = 0.
  - Array contents are not reset directly.
- Clear FSM has two states, CLEAR and RUN.
  - CLEAR: each cycle writes 0 to entry clr_cnt, then clr_cnt += 1. At clr_cnt == DEPTH-1 the FSM moves to RUN on the next edge.
  - The sweep takes exactly DEPTH cycles after rst_n rises. init_busy drops in the cycle after entry DEPTH-1 is cleared.
  - RUN: terminal state; only reset leaves it.
- During CLEAR:
  - wr_en is ignored; nothing is written.
  - rd_data holds 0 regardless of rd_en.
- Reset asserted mid-sweep: sweep aborts and restarts from entry 0 after release.
- Write (RUN): on a rising edge with wr_en = 1, mem[wr_addr] <= wr_data.
- Read (RUN), latency 1 cycle:
  - If rd_en[i] = 1 at edge N, rd_data port i holds the read value from edge N until the next enabled read.
  - If rd_en[i] = 0, port i holds its previous value.
- Bypass: if wr_en = 1, rd_en[i] = 1 and rd_addr[i] == wr_addr at the same edge, port i returns wr_data, not the stale entry.
- Multiple ports reading the same address in the same cycle all return the same value, with bypass applied to each port.
- No other read/write conflicts exist (single write port).
- Width rules: no truncation or extension; all addresses are in range since DEPTH = 2**ADDR_W.

Optional Feature:
- Macro: REG_FILE_MP_ZERO_REG_EN.
- Defined:
  - Entry 0 is hard-wired zero; writes to address 0 are discarded.
  - Reads of address 0 return 0, including the bypass case with wr_addr == 0 and wr_data != 0.
  - The clear sweep still runs for DEPTH cycles (timing unchanged).
- Undefined: entry 0 is an ordinary register.

Decomposition:
- Shared package reg_file_pkg:
  - default DATA_W / ADDR_W / NUM_RD constants;
  - clear FSM state typedef (CLEAR, RUN).
- One sub-module, reg_file_clear_seq: owns the FSM, clr_cnt and init_busy, and outputs clr_we / clr_addr.
- The top muxes the write port between the clear sequencer and the external write.
- Read ports use a generate loop in the top; no separate sub-module.

Test Plan:
- Reset release: hold rst_n low for 3 cycles, then release.
  - init_busy stays 1 for exactly 32 cycles, then 0.
  - Reading all 32 addresses on both ports returns 0.
- Fill/readback: write data = addr*3 to addresses 0..31 (one per cycle), then read port0 = a and port1 = 31-a for a = 0..31.
  - Each port returns the matching value one cycle after its address is presented.
- Bypass: write 24'hABCDEF to addr 7 while port0 reads 7 in the same cycle → rd_data port0 = 24'hABCDEF next cycle.
  - A following read of 7 also returns 24'hABCDEF.
- Hold and ignore:
  - With rd_en = 0 for 5 cycles while writes continue, rd_data is unchanged.
  - wr_en pulses during CLEAR leave entries 0 after the sweep.
- Mid-sweep reset: assert rst_n low at sweep cycle 10, release.
  - init_busy stays 1 for another full 32 cycles.
  - Entries written before the reset read back 0.
- With REG_FILE_MP_ZERO_REG_EN defined: write 24'h123456 to addr 0 with a simultaneous read of 0 → rd_data = 0 both in that cycle's result and on later reads.
  - Same test without the macro returns 24'h123456.
